// File: rtl/uart_cmd_rx.sv
// UART command receiver: deserialises host bytes, parses 5-byte command packets and issues
// SCCB register-write requests or frame-request strobes.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned UART_BPS    = 115_200,
  parameter int unsigned TIMEOUT_CYC = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       reg_wr_done,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       frame_req,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int unsigned BitCnt  = CLK_FREQ / UART_BPS;
  localparam int unsigned HalfCnt = BitCnt / 2;
  localparam int unsigned CntW    = $clog2(BitCnt + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCnt - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCnt - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {PsSync, PsCmd, PsAddr, PsData, PsChk, PsWaitAck} ps_state_e;

  // ---------------- bit receiver ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RxIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rxd;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + CntW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // Needs a seen-high level first, so a low stop bit cannot re-trigger a start.
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d        = '0;
          rx_state_d   = RxIdle;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- packet parser ----------------
  ps_state_e       ps_q, ps_d;
  logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit, chk_ok, accept;
  logic            reg_wr_en_q, reg_wr_en_d, frame_req_q, frame_req_d, cmd_err_q, cmd_err_d;
  logic [7:0]      reg_addr_q, reg_addr_d, reg_data_q, reg_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q        <= PsSync;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      frame_req_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      ps_q        <= ps_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      frame_req_q <= frame_req_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign tmo_hit = (tmo_q == TmoLast);
  assign chk_ok  = (shift_q == (cmd_q ^ addr_q ^ data_q));
  assign accept  = byte_valid_q && (ps_q == PsChk);

  always_comb begin
    ps_d   = ps_q;
    cmd_d  = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    tmo_d  = '0;
    if ((ps_q inside {PsCmd, PsAddr, PsData, PsChk}) && !byte_valid_q && !tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end
    // A valid byte takes priority over a simultaneous timeout expiry.
    unique case (ps_q)
      PsSync: if (byte_valid_q && shift_q == 8'h55) ps_d = PsCmd;
      PsCmd: begin
        if (byte_valid_q) begin
          cmd_d = shift_q;
          ps_d  = PsAddr;
        end else if (tmo_hit) ps_d = PsSync;
      end
      PsAddr: begin
        if (byte_valid_q) begin
          addr_d = shift_q;
          ps_d   = PsData;
        end else if (tmo_hit) ps_d = PsSync;
      end
      PsData: begin
        if (byte_valid_q) begin
          data_d = shift_q;
          ps_d   = PsChk;
        end else if (tmo_hit) ps_d = PsSync;
      end
      PsChk: begin
        if (byte_valid_q) ps_d = (chk_ok && cmd_q == 8'h01) ? PsWaitAck : PsSync;
        else if (tmo_hit) ps_d = PsSync;
      end
      PsWaitAck: if (reg_wr_done) ps_d = PsSync;
      default:   ps_d = PsSync;
    endcase
    // An outstanding write request is never abandoned on a framing error.
    if (frame_err_q && ps_q != PsWaitAck) ps_d = PsSync;
  end

  always_comb begin
    reg_wr_en_d = reg_wr_en_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    frame_req_d = accept && chk_ok && (cmd_q == 8'h02);
    cmd_err_d   = (accept && !(chk_ok && (cmd_q == 8'h01 || cmd_q == 8'h02)))
               || (byte_valid_q && ps_q == PsWaitAck);
    if (accept && chk_ok && cmd_q == 8'h01) begin
      reg_wr_en_d = 1'b1;
      reg_addr_d  = addr_q;
      reg_data_d  = data_q;
    end else if (ps_q == PsWaitAck && reg_wr_done) begin
      reg_wr_en_d = 1'b0;
    end
  end

  assign reg_wr_en = reg_wr_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;
  assign frame_req = frame_req_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial packets driven at a fast baud with a short timeout.
module tb_uart_cmd_rx;

  localparam int unsigned ClkFreq = 25_000_000;
  localparam int unsigned Bps     = 1_562_500;
  localparam int unsigned Tmo     = 2000;
  localparam int unsigned Bit     = ClkFreq / Bps;  // 16 clocks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       reg_wr_done = 1'b0;
  logic       reg_wr_en, frame_req, cmd_err, frame_err;
  logic [7:0] reg_addr, reg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_freq = 0, cnt_cerr = 0, cnt_ferr = 0, cnt_wr = 0;
  logic wr_prev = 1'b0;

  uart_cmd_rx #(
    .CLK_FREQ   (ClkFreq),
    .UART_BPS   (Bps),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .reg_wr_done(reg_wr_done),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .frame_req  (frame_req),
    .cmd_err    (cmd_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitors: count high cycles of each strobe and rising edges of reg_wr_en.
  always @(negedge clk) begin
    if (frame_req === 1'b1) cnt_freq++;
    if (cmd_err === 1'b1) cnt_cerr++;
    if (frame_err === 1'b1) cnt_ferr++;
    if (reg_wr_en === 1'b1 && wr_prev !== 1'b1) cnt_wr++;
    wr_prev = reg_wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (Bit) @(negedge clk);
    uart_rxd = 1'b1;
    if (!stop) repeat (Bit) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] k);
    send_byte(8'h55, 1'b1);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(k, 1'b1);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 200 && reg_wr_en !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic pulse_done();
    reg_wr_done = 1'b1;
    @(negedge clk);
    reg_wr_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", reg_addr); end
    n_checks++; if (reg_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", reg_data); end
    n_checks++; if (frame_req !== 1'b0) begin n_fail++; $display("FAIL reset_freq got %b exp 0", frame_req); end
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cerr got %b exp 0", cmd_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    rst = 1'b0;
    repeat (4 * Bit) @(negedge clk);
  endtask

  task automatic test_write();
    int c0, f0, drops;
    c0 = cnt_cerr; f0 = cnt_freq; drops = 0;
    send_pkt(8'h01, 8'h12, 8'h80, 8'h93);
    wait_en();
    n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_en got %b exp 1", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'h12) begin n_fail++; $display("FAIL wr_addr got %h exp 12", reg_addr); end
    n_checks++; if (reg_data !== 8'h80) begin n_fail++; $display("FAIL wr_data got %h exp 80", reg_data); end
    repeat (40) begin
      @(negedge clk);
      if (reg_wr_en !== 1'b1) drops++;
    end
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL wr_hold low_cycles %0d exp 0", drops); end
    pulse_done();
    n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_release got %b exp 0", reg_wr_en); end
    n_checks++; if (cnt_cerr - c0 != 0) begin n_fail++; $display("FAIL wr_cmd_err got %0d exp 0", cnt_cerr - c0); end
    n_checks++; if (cnt_freq - f0 != 0) begin n_fail++; $display("FAIL wr_freq got %0d exp 0", cnt_freq - f0); end
    repeat (2 * Bit) @(negedge clk);
  endtask

  task automatic test_frame_req();
    int f0, w0, c0;
    f0 = cnt_freq; w0 = cnt_wr; c0 = cnt_cerr;
    send_pkt(8'h02, 8'h00, 8'h00, 8'h02);
    repeat (20) @(negedge clk);
    n_checks++; if (cnt_freq - f0 != 1) begin n_fail++; $display("FAIL freq_cycles got %0d exp 1", cnt_freq - f0); end
    n_checks++; if (cnt_wr - w0 != 0) begin n_fail++; $display("FAIL freq_wr got %0d exp 0", cnt_wr - w0); end
    n_checks++; if (cnt_cerr - c0 != 0) begin n_fail++; $display("FAIL freq_cerr got %0d exp 0", cnt_cerr - c0); end
  endtask

  task automatic test_bad_chk();
    int c0, w0;
    c0 = cnt_cerr; w0 = cnt_wr;
    send_pkt(8'h01, 8'h12, 8'h80, 8'h94);
    repeat (20) @(negedge clk);
    n_checks++; if (cnt_cerr - c0 != 1) begin n_fail++; $display("FAIL badchk_cerr got %0d exp 1", cnt_cerr - c0); end
    n_checks++; if (cnt_wr - w0 != 0) begin n_fail++; $display("FAIL badchk_wr got %0d exp 0", cnt_wr - w0); end
    send_pkt(8'h01, 8'hAB, 8'hCD, 8'h67);
    wait_en();
    n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL after_bad_en got %b exp 1", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'hAB) begin n_fail++; $display("FAIL after_bad_addr got %h exp ab", reg_addr); end
    n_checks++; if (reg_data !== 8'hCD) begin n_fail++; $display("FAIL after_bad_data got %h exp cd", reg_data); end
    pulse_done();
    repeat (2 * Bit) @(negedge clk);
  endtask

  task automatic test_frame_err();
    int e0, c0;
    e0 = cnt_ferr; c0 = cnt_cerr;
    send_byte(8'h55, 1'b0);
    n_checks++; if (cnt_ferr - e0 != 1) begin n_fail++; $display("FAIL ferr_cycles got %0d exp 1", cnt_ferr - e0); end
    send_byte(8'hAA, 1'b1);
    send_pkt(8'h01, 8'h3D, 8'h03, 8'h3F);
    wait_en();
    n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL ferr_wr_en got %b exp 1", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'h3D) begin n_fail++; $display("FAIL ferr_addr got %h exp 3d", reg_addr); end
    n_checks++; if (reg_data !== 8'h03) begin n_fail++; $display("FAIL ferr_data got %h exp 03", reg_data); end
    n_checks++; if (cnt_cerr - c0 != 0) begin n_fail++; $display("FAIL ferr_cerr got %0d exp 0", cnt_cerr - c0); end
    pulse_done();
    repeat (2 * Bit) @(negedge clk);
  endtask

  task automatic test_timeout();
    int w0, c0, f0;
    w0 = cnt_wr; c0 = cnt_cerr; f0 = cnt_freq;
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (Tmo + 200) @(negedge clk);
    send_byte(8'h12, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h93, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++; if (cnt_wr - w0 != 0) begin n_fail++; $display("FAIL tmo_wr got %0d exp 0", cnt_wr - w0); end
    n_checks++; if (cnt_cerr - c0 != 0) begin n_fail++; $display("FAIL tmo_cerr got %0d exp 0", cnt_cerr - c0); end
    n_checks++; if (cnt_freq - f0 != 0) begin n_fail++; $display("FAIL tmo_freq got %0d exp 0", cnt_freq - f0); end
    // Gap below the timeout, plus a short low glitch that must not become a byte.
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (Tmo - 600) @(negedge clk);
    uart_rxd = 1'b0;
    repeat (Bit / 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * Bit) @(negedge clk);
    send_byte(8'h80, 1'b1);
    send_byte(8'h93, 1'b1);
    wait_en();
    n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL glitch_wr_en got %b exp 1", reg_wr_en); end
    n_checks++; if (reg_data !== 8'h80) begin n_fail++; $display("FAIL glitch_data got %h exp 80", reg_data); end
    n_checks++; if (cnt_ferr != 1) begin n_fail++; $display("FAIL glitch_ferr total %0d exp 1", cnt_ferr); end
    pulse_done();
    repeat (2 * Bit) @(negedge clk);
  endtask

  task automatic test_busy_and_reset();
    int c0, drops;
    drops = 0;
    send_pkt(8'h01, 8'h22, 8'h44, 8'h67);
    wait_en();
    c0 = cnt_cerr;
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    n_checks++; if (cnt_cerr - c0 != 1) begin n_fail++; $display("FAIL busy_cerr got %0d exp 1", cnt_cerr - c0); end
    n_checks++; if (reg_wr_en !== 1'b1) begin n_fail++; $display("FAIL busy_wr_en got %b exp 1", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'h22) begin n_fail++; $display("FAIL busy_addr got %h exp 22", reg_addr); end
    // Reset mid-byte with the write still outstanding, after a partial packet header.
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rxd = 1'b0;
    repeat (3 * Bit) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got %b exp 0", reg_wr_en); end
    n_checks++; if (reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %h exp 00", reg_addr); end
    n_checks++; if (reg_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", reg_data); end
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * Bit) @(negedge clk);
    c0 = cnt_cerr;
    // Parser stuck in ADDR would flag a checksum error on these four bytes.
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (20) @(negedge clk);
    n_checks++; if (cnt_cerr - c0 != 0) begin n_fail++; $display("FAIL rst_sync_cerr got %0d exp 0", cnt_cerr - c0); end
    repeat (20) begin
      @(negedge clk);
      if (reg_wr_en !== 1'b0) drops++;
    end
    n_checks++; if (drops != 0) begin n_fail++; $display("FAIL rst_sync_wr high_cycles %0d exp 0", drops); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_frame_req();
    test_bad_chk();
    test_frame_err();
    test_timeout();
    test_busy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
